// File: rtl/reg_file_mp_pkg.sv
// Shared defaults for the multi-port register file: datapath widths and the
// hardwired zero-register index used by decode, writeback and the file itself.
package reg_file_mp_pkg;
  localparam int RF_DATA_W   = 24;
  localparam int RF_ADDR_W   = 4;
  localparam int RF_NUM_REGS = 16;
  localparam int RF_ZERO_IDX = 0;
endpackage

// File: rtl/reg_file_mp_if.sv
// Bundle of read, write-lane and alloc signals between the pipeline (master)
// and the register file (slave).
interface reg_file_mp_if
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W     = RF_DATA_W,
  parameter int ADDR_W     = RF_ADDR_W,
  parameter int READ_PORTS = 2
);
  // No handshake: reads and alloc status are combinational, writes/allocs
  // are sampled on every rising clock edge while their enables are high.
  logic [READ_PORTS*ADDR_W-1:0] ReadAddr;
  logic [READ_PORTS*DATA_W-1:0] ReadData;
  logic [READ_PORTS-1:0]        ReadBusy;
  logic                         WriteEn0;
  logic [ADDR_W-1:0]            WriteAddr0;
  logic [DATA_W-1:0]            WriteData0;
  logic                         WriteEn1;
  logic [ADDR_W-1:0]            WriteAddr1;
  logic [DATA_W-1:0]            WriteData1;
  logic                         AllocEn;
  logic [ADDR_W-1:0]            AllocAddr;
  logic                         AllocBusy;

  modport master (
    output ReadAddr, WriteEn0, WriteAddr0, WriteData0,
           WriteEn1, WriteAddr1, WriteData1, AllocEn, AllocAddr,
    input  ReadData, ReadBusy, AllocBusy
  );

  modport slave (
    input  ReadAddr, WriteEn0, WriteAddr0, WriteData0,
           WriteEn1, WriteAddr1, WriteData1, AllocEn, AllocAddr,
    output ReadData, ReadBusy, AllocBusy
  );
endinterface

// File: rtl/reg_file_mp_read_port.sv
// One combinational read port: array mux, range/zero check, write-lane bypass
// and busy reporting for a single read address.
module reg_file_mp_read_port
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              rstN,
  input  logic [ADDR_W-1:0] readAddr,
  input  logic [DATA_W-1:0] regs [NUM_REGS],
  input  logic [NUM_REGS-1:0] busy,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  output logic [DATA_W-1:0] readData,
  output logic              readBusy
);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_REGS);

  logic addrOk;
  logic hit0;
  logic hit1;

  always_comb begin
    addrOk   = rstN && ({1'b0, readAddr} < LIMIT)
               && !((ZERO_REG != 0) && (readAddr == ADDR_W'(RF_ZERO_IDX)));
    hit0     = (BYPASS != 0) && we0 && (wa0 == readAddr);
    hit1     = (BYPASS != 0) && we1 && (wa1 == readAddr);
    readData = '0;
    readBusy = 1'b0;
    if (addrOk) begin
      // Lane 1 is the younger retire, so its data is the architecturally newest.
      if (hit1)      readData = wd1;
      else if (hit0) readData = wd0;
      else           readData = regs[readAddr];
      readBusy = busy[readAddr] && !(hit0 || hit1);
    end
  end
endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: storage array, two prioritised write lanes and a
// per-register busy scoreboard; read ports are generated from rf_read_port logic.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W     = RF_DATA_W,
  parameter int ADDR_W     = RF_ADDR_W,
  parameter int NUM_REGS   = RF_NUM_REGS,
  parameter int READ_PORTS = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input logic          Clock,
  input logic          Reset_n,
  reg_file_mp_if.slave bus
);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_REGS);

  logic [DATA_W-1:0]            regs [NUM_REGS];
  logic [NUM_REGS-1:0]          busy;
  logic [NUM_REGS-1:0]          wHit0;
  logic [NUM_REGS-1:0]          wHit1;
  logic [NUM_REGS-1:0]          aHit;
  logic                         allocOk;
  logic [READ_PORTS*DATA_W-1:0] rdData;
  logic [READ_PORTS-1:0]        rdBusy;

  // Per-register decode; out-of-range addresses never match any index.
  always_comb begin
    wHit0 = '0;
    wHit1 = '0;
    aHit  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!((ZERO_REG != 0) && (i == RF_ZERO_IDX))) begin
        wHit0[i] = bus.WriteEn0 && (bus.WriteAddr0 == ADDR_W'(i));
        wHit1[i] = bus.WriteEn1 && (bus.WriteAddr1 == ADDR_W'(i));
        aHit[i]  = bus.AllocEn  && (bus.AllocAddr  == ADDR_W'(i));
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wHit1[i])      regs[i] <= bus.WriteData1;
        else if (wHit0[i]) regs[i] <= bus.WriteData0;
        // A new producer issued in the same cycle as a retire keeps the register busy.
        if (aHit[i])                    busy[i] <= 1'b1;
        else if (wHit0[i] || wHit1[i])  busy[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    allocOk = ({1'b0, bus.AllocAddr} < LIMIT)
              && !((ZERO_REG != 0) && (bus.AllocAddr == ADDR_W'(RF_ZERO_IDX)));
    bus.AllocBusy = allocOk && busy[bus.AllocAddr];
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
    reg_file_mp_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_REGS(NUM_REGS),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_port (
      .rstN    (Reset_n),
      .readAddr(bus.ReadAddr[p*ADDR_W +: ADDR_W]),
      .regs    (regs),
      .busy    (busy),
      .we0     (bus.WriteEn0),
      .wa0     (bus.WriteAddr0),
      .wd0     (bus.WriteData0),
      .we1     (bus.WriteEn1),
      .wa1     (bus.WriteAddr1),
      .wd1     (bus.WriteData1),
      .readData(rdData[p*DATA_W +: DATA_W]),
      .readBusy(rdBusy[p])
    );
  end

  assign bus.ReadData = rdData;
  assign bus.ReadBusy = rdBusy;
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a default build (16 regs, bypass) and a
// reduced build (12 regs, no bypass) sharing one clock and reset.
module tb_reg_file_mp;
  logic clk;
  logic rstN;
  int   checks;
  int   errors;

  reg_file_mp_if #(.DATA_W(24), .ADDR_W(4), .READ_PORTS(2)) busA ();
  reg_file_mp_if #(.DATA_W(24), .ADDR_W(4), .READ_PORTS(2)) busB ();

  reg_file_mp #(.DATA_W(24), .ADDR_W(4), .NUM_REGS(16), .READ_PORTS(2),
                .ZERO_REG(1), .BYPASS(1)) dutA (.Clock(clk), .Reset_n(rstN), .bus(busA));
  reg_file_mp #(.DATA_W(24), .ADDR_W(4), .NUM_REGS(12), .READ_PORTS(2),
                .ZERO_REG(1), .BYPASS(0)) dutB (.Clock(clk), .Reset_n(rstN), .bus(busB));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic idle();
    busA.WriteEn0 = 0; busA.WriteAddr0 = '0; busA.WriteData0 = '0;
    busA.WriteEn1 = 0; busA.WriteAddr1 = '0; busA.WriteData1 = '0;
    busA.AllocEn  = 0; busA.AllocAddr  = '0;
    busB.WriteEn0 = 0; busB.WriteAddr0 = '0; busB.WriteData0 = '0;
    busB.WriteEn1 = 0; busB.WriteAddr1 = '0; busB.WriteData1 = '0;
    busB.AllocEn  = 0; busB.AllocAddr  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    busA.ReadAddr = {4'd2, 4'd1};
    busA.AllocAddr = 4'd4;
    #1;
    checks++;
    if (busA.ReadData !== 48'h0 || busA.ReadBusy !== 2'b00 || busA.AllocBusy !== 1'b0) begin
      errors++; $display("FAIL reset_state: data=%h busy=%b alloc=%b exp 0", busA.ReadData, busA.ReadBusy, busA.AllocBusy);
    end
    busA.WriteEn0 = 1; busA.WriteAddr0 = 4'd8; busA.WriteData0 = 24'd5;
    busA.AllocEn = 1; busA.AllocAddr = 4'd4;
    tick();
    idle();
    busA.ReadAddr = {4'd4, 4'd8};
    busA.AllocAddr = 4'd4;
    #1;
    checks++;
    if (busA.ReadData[23:0] !== 24'd5) begin
      errors++; $display("FAIL reset_pre_r8: got %h exp %h", busA.ReadData[23:0], 24'd5);
    end
    checks++;
    if (busA.ReadBusy !== 2'b10 || busA.AllocBusy !== 1'b1) begin
      errors++; $display("FAIL reset_pre_busy: busy=%b alloc=%b exp 10/1", busA.ReadBusy, busA.AllocBusy);
    end
    rstN = 0;
    #1;
    checks++;
    if (busA.ReadData[23:0] !== 24'd0) begin
      errors++; $display("FAIL reset_async_data: got %h exp 0", busA.ReadData[23:0]);
    end
    checks++;
    if (busA.ReadBusy !== 2'b00 || busA.AllocBusy !== 1'b0) begin
      errors++; $display("FAIL reset_async_busy: busy=%b alloc=%b exp 00/0", busA.ReadBusy, busA.AllocBusy);
    end
    rstN = 1;
    #1;
  endtask

  task automatic test_write_priority();
    busA.WriteEn0 = 1; busA.WriteAddr0 = 4'd9; busA.WriteData0 = 24'd7;
    busA.WriteEn1 = 1; busA.WriteAddr1 = 4'd9; busA.WriteData1 = 24'd9;
    busA.ReadAddr = {4'd9, 4'd9};
    #1;
    checks++;
    if (busA.ReadData !== {24'd9, 24'd9}) begin
      errors++; $display("FAIL prio_bypass: got %h exp %h", busA.ReadData, {24'd9, 24'd9});
    end
    tick();
    idle();
    #1;
    checks++;
    if (busA.ReadData[23:0] !== 24'd9) begin
      errors++; $display("FAIL prio_stored: got %h exp %h", busA.ReadData[23:0], 24'd9);
    end
    busA.WriteEn0 = 1; busA.WriteAddr0 = 4'd10; busA.WriteData0 = 24'hABCDEF;
    busA.ReadAddr = {4'd10, 4'd9};
    #1;
    checks++;
    if (busA.ReadData[47:24] !== 24'hABCDEF) begin
      errors++; $display("FAIL lane0_bypass: got %h exp %h", busA.ReadData[47:24], 24'hABCDEF);
    end
    tick();
    idle();
  endtask

  task automatic test_zero_reg();
    busA.WriteEn0 = 1; busA.WriteAddr0 = 4'd0; busA.WriteData0 = 24'hFFFFFF;
    busA.AllocEn = 1; busA.AllocAddr = 4'd0;
    busA.ReadAddr = {4'd0, 4'd0};
    #1;
    checks++;
    if (busA.ReadData !== 48'h0 || busA.ReadBusy !== 2'b00) begin
      errors++; $display("FAIL zero_bypass: data=%h busy=%b exp 0", busA.ReadData, busA.ReadBusy);
    end
    tick();
    idle();
    busA.AllocAddr = 4'd0;
    #1;
    checks++;
    if (busA.ReadData[23:0] !== 24'd0 || busA.ReadBusy[0] !== 1'b0 || busA.AllocBusy !== 1'b0) begin
      errors++; $display("FAIL zero_after: data=%h busy=%b alloc=%b exp 0", busA.ReadData[23:0], busA.ReadBusy[0], busA.AllocBusy);
    end
  endtask

  task automatic test_scoreboard();
    busA.AllocEn = 1; busA.AllocAddr = 4'd3;
    busA.ReadAddr = {4'd3, 4'd1};
    #1;
    checks++;
    if (busA.AllocBusy !== 1'b0 || busA.ReadBusy[1] !== 1'b0) begin
      errors++; $display("FAIL sb_pre_alloc: alloc=%b busy=%b exp 0/0", busA.AllocBusy, busA.ReadBusy[1]);
    end
    tick();
    idle();
    busA.AllocAddr = 4'd3;
    #1;
    checks++;
    if (busA.ReadBusy[1] !== 1'b1 || busA.AllocBusy !== 1'b1) begin
      errors++; $display("FAIL sb_busy_set: busy=%b alloc=%b exp 1/1", busA.ReadBusy[1], busA.AllocBusy);
    end
    busA.WriteEn1 = 1; busA.WriteAddr1 = 4'd3; busA.WriteData1 = 24'h123456;
    #1;
    checks++;
    if (busA.ReadBusy[1] !== 1'b0 || busA.ReadData[47:24] !== 24'h123456) begin
      errors++; $display("FAIL sb_bypass: busy=%b data=%h exp 0/123456", busA.ReadBusy[1], busA.ReadData[47:24]);
    end
    checks++;
    if (busA.AllocBusy !== 1'b1) begin
      errors++; $display("FAIL sb_alloc_no_bypass: got %b exp 1", busA.AllocBusy);
    end
    tick();
    idle();
    busA.AllocAddr = 4'd3;
    #1;
    checks++;
    if (busA.ReadBusy[1] !== 1'b0 || busA.AllocBusy !== 1'b0 || busA.ReadData[47:24] !== 24'h123456) begin
      errors++; $display("FAIL sb_cleared: busy=%b alloc=%b data=%h exp 0/0/123456", busA.ReadBusy[1], busA.AllocBusy, busA.ReadData[47:24]);
    end
  endtask

  task automatic test_alloc_write();
    busA.AllocEn = 1; busA.AllocAddr = 4'd5;
    busA.WriteEn0 = 1; busA.WriteAddr0 = 4'd5; busA.WriteData0 = 24'h00A5A5;
    tick();
    idle();
    busA.ReadAddr = {4'd1, 4'd5};
    #1;
    checks++;
    if (busA.ReadData[23:0] !== 24'h00A5A5 || busA.ReadBusy[0] !== 1'b1) begin
      errors++; $display("FAIL alloc_write: data=%h busy=%b exp 00a5a5/1", busA.ReadData[23:0], busA.ReadBusy[0]);
    end
  endtask

  task automatic test_back_to_back();
    busA.WriteEn0 = 1; busA.WriteAddr0 = 4'd6; busA.WriteData0 = 24'h000060;
    busA.WriteEn1 = 1; busA.WriteAddr1 = 4'd7; busA.WriteData1 = 24'h000070;
    tick();
    busA.WriteEn0 = 1; busA.WriteAddr0 = 4'd15; busA.WriteData0 = 24'h0F0F0F;
    busA.WriteEn1 = 0;
    tick();
    idle();
    busA.ReadAddr = {4'd7, 4'd6};
    #1;
    checks++;
    if (busA.ReadData !== {24'h000070, 24'h000060}) begin
      errors++; $display("FAIL b2b_lanes: got %h exp %h", busA.ReadData, {24'h000070, 24'h000060});
    end
    busA.ReadAddr = {4'd15, 4'd9};
    #1;
    checks++;
    if (busA.ReadData !== {24'h0F0F0F, 24'd9}) begin
      errors++; $display("FAIL b2b_top_reg: got %h exp %h", busA.ReadData, {24'h0F0F0F, 24'd9});
    end
  endtask

  task automatic test_range_nobypass();
    busB.WriteEn0 = 1; busB.WriteAddr0 = 4'd13; busB.WriteData0 = 24'd1;
    busB.WriteEn1 = 1; busB.WriteAddr1 = 4'd11; busB.WriteData1 = 24'h000777;
    busB.ReadAddr = {4'd11, 4'd13};
    #1;
    checks++;
    if (busB.ReadData !== 48'h0) begin
      errors++; $display("FAIL nobypass_pre: got %h exp 0", busB.ReadData);
    end
    tick();
    idle();
    busB.AllocEn = 1; busB.AllocAddr = 4'd13;
    #1;
    checks++;
    if (busB.ReadData !== {24'h000777, 24'd0} || busB.ReadBusy !== 2'b00) begin
      errors++; $display("FAIL range_read: data=%h busy=%b exp %h/00", busB.ReadData, busB.ReadBusy, {24'h000777, 24'd0});
    end
    tick();
    idle();
    busB.AllocAddr = 4'd13;
    #1;
    checks++;
    if (busB.AllocBusy !== 1'b0 || busB.ReadBusy[0] !== 1'b0) begin
      errors++; $display("FAIL range_alloc: alloc=%b busy=%b exp 0/0", busB.AllocBusy, busB.ReadBusy[0]);
    end
    busB.WriteEn0 = 1; busB.WriteAddr0 = 4'd2; busB.WriteData0 = 24'h000111;
    tick();
    busB.WriteData0 = 24'h000222;
    busB.ReadAddr = {4'd1, 4'd2};
    #1;
    checks++;
    if (busB.ReadData[23:0] !== 24'h000111) begin
      errors++; $display("FAIL nobypass_old: got %h exp %h", busB.ReadData[23:0], 24'h000111);
    end
    tick();
    idle();
    #1;
    checks++;
    if (busB.ReadData[23:0] !== 24'h000222) begin
      errors++; $display("FAIL nobypass_new: got %h exp %h", busB.ReadData[23:0], 24'h000222);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstN = 0;
    idle();
    busA.ReadAddr = '0;
    busB.ReadAddr = '0;
    #13;
    rstN = 1;
    test_reset();
    test_write_priority();
    test_zero_reg();
    test_scoreboard();
    test_alloc_write();
    test_back_to_back();
    test_range_nobypass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
